// File: rtl/fpga_coproc_pkg.sv
// Shared definitions for the polynomial coprocessor: FSM states, mode codes
// and the mode-decoding helper.
package fpga_coproc_pkg;

  localparam int MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    MUL2 = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam mode_t MODE_SQ   = 2'd0;  // x*x
  localparam mode_t MODE_SQ_K = 2'd1;  // x*x + K
  localparam mode_t MODE_POLY = 2'd2;  // (x*x + K)^2
  localparam mode_t MODE_PASS = 2'd3;  // x

  // Modes that route through the adder after the first square
  function automatic logic needs_add(input mode_t m);
    return (m == MODE_SQ_K) || (m == MODE_POLY);
  endfunction

endpackage

// File: rtl/fpga_coproc_poly_sync_bus.sv
// Multi-flop synchroniser for a bus of quasi-static signals; every stage
// resets to zero.
module sync_bus #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[STAGES-2:0], d};
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/fpga_coproc_poly.sv
// MCU-port polynomial coprocessor: toggle-tag handshake, one shared adder and
// multiplier. Define FPGA_COPROC_OVERFLOW_EN to add the sticky overflow output.
module fpga_coproc_poly #(
  parameter int DATA_W      = 8,
  parameter int RESULT_W    = 8,
  parameter int ADD_K       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [1:0]          mode_in,
  input  logic                tag_in,
  output logic [RESULT_W-1:0] result,
  output logic                ack_tag,
  output logic                busy
`ifdef FPGA_COPROC_OVERFLOW_EN
  ,
  output logic                overflow
`endif
);

  import fpga_coproc_pkg::*;

  localparam int SW = 1 + MODE_W + DATA_W;
  localparam logic [RESULT_W-1:0] K = RESULT_W'(ADD_K);
`ifdef FPGA_COPROC_OVERFLOW_EN
  localparam int PW = 2 * RESULT_W;
`else
  localparam int PW = RESULT_W;
`endif

  // Tag, mode and data share one synchroniser so they age together
  logic [SW-1:0]       sync_q;
  logic                tag_s;
  mode_t               mode_s;
  logic [DATA_W-1:0]   data_s;
  logic [RESULT_W-1:0] x_s;

  sync_bus #(
    .WIDTH  (SW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       ({tag_in, mode_in, data_in}),
    .q       (sync_q)
  );

  assign tag_s  = sync_q[SW-1];
  assign mode_s = sync_q[SW-2 -: MODE_W];
  assign data_s = sync_q[DATA_W-1:0];
  assign x_s    = RESULT_W'(data_s);

  state_t              state_reg,    state_next;
  logic                first_reg,    first_next;
  logic                prev_tag_reg, prev_tag_next;
  logic [RESULT_W-1:0] x_reg,        x_next;
  mode_t               mode_reg,     mode_next;
  logic [RESULT_W-1:0] r_mul_reg,    r_mul_next;
  logic [RESULT_W-1:0] r_add_reg,    r_add_next;
  logic [RESULT_W-1:0] result_reg,   result_next;
  logic                ack_reg,      ack_next;

  // Shared arithmetic units; inputs are held at zero when unused
  logic [RESULT_W-1:0] mul_a, mul_b, add_a, add_b;
  logic [PW-1:0]       mul_full;
  logic [RESULT_W-1:0] mul_p, add_p;

  assign mul_full = PW'(mul_a) * PW'(mul_b);
  assign mul_p    = mul_full[RESULT_W-1:0];

`ifdef FPGA_COPROC_OVERFLOW_EN
  logic [RESULT_W:0]   add_full;
  logic                mul_ovf, add_ovf;
  logic                ovf_acc_reg, ovf_acc_next;
  logic                ovf_reg,     ovf_next;

  assign add_full = {1'b0, add_a} + {1'b0, add_b};
  assign add_p    = add_full[RESULT_W-1:0];
  assign add_ovf  = add_full[RESULT_W];
  assign mul_ovf  = |mul_full[PW-1:RESULT_W];
`else
  assign add_p = add_a + add_b;
`endif

  always_comb begin
    state_next    = state_reg;
    first_next    = first_reg;
    prev_tag_next = prev_tag_reg;
    x_next        = x_reg;
    mode_next     = mode_reg;
    r_mul_next    = r_mul_reg;
    r_add_next    = r_add_reg;
    result_next   = result_reg;
    ack_next      = ack_reg;
    mul_a         = '0;
    mul_b         = '0;
    add_a         = '0;
    add_b         = '0;
`ifdef FPGA_COPROC_OVERFLOW_EN
    ovf_acc_next  = ovf_acc_reg;
    ovf_next      = ovf_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (first_reg) begin
          // Adopt whatever tag level the host left; no request on wake-up
          prev_tag_next = tag_s;
          first_next    = 1'b0;
        end else if (tag_s != prev_tag_reg) begin
          prev_tag_next = tag_s;
          x_next        = x_s;
          mode_next     = mode_s;
          mul_a         = x_s;
          mul_b         = x_s;
          r_mul_next    = mul_p;
`ifdef FPGA_COPROC_OVERFLOW_EN
          ovf_acc_next  = mul_ovf;
          ovf_next      = 1'b0;
`endif
          state_next    = needs_add(mode_s) ? ADD : DONE;
        end
      end

      ADD: begin
        add_a      = r_mul_reg;
        add_b      = K;
        r_add_next = add_p;
`ifdef FPGA_COPROC_OVERFLOW_EN
        ovf_acc_next = ovf_acc_reg | add_ovf;
`endif
        state_next = (mode_reg == MODE_POLY) ? MUL2 : DONE;
      end

      MUL2: begin
        mul_a      = r_add_reg;
        mul_b      = r_add_reg;
        r_mul_next = mul_p;
`ifdef FPGA_COPROC_OVERFLOW_EN
        ovf_acc_next = ovf_acc_reg | mul_ovf;
`endif
        state_next = DONE;
      end

      DONE: begin
        case (mode_reg)
          MODE_SQ_K: result_next = r_add_reg;
          MODE_PASS: result_next = x_reg;
          default:   result_next = r_mul_reg;
        endcase
        ack_next   = ~ack_reg;
`ifdef FPGA_COPROC_OVERFLOW_EN
        ovf_next   = ovf_acc_reg;
`endif
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      first_reg    <= 1'b1;
      prev_tag_reg <= 1'b0;
      x_reg        <= '0;
      mode_reg     <= MODE_SQ;
      r_mul_reg    <= '0;
      r_add_reg    <= '0;
      result_reg   <= '0;
      ack_reg      <= 1'b0;
`ifdef FPGA_COPROC_OVERFLOW_EN
      ovf_acc_reg  <= 1'b0;
      ovf_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      first_reg    <= first_next;
      prev_tag_reg <= prev_tag_next;
      x_reg        <= x_next;
      mode_reg     <= mode_next;
      r_mul_reg    <= r_mul_next;
      r_add_reg    <= r_add_next;
      result_reg   <= result_next;
      ack_reg      <= ack_next;
`ifdef FPGA_COPROC_OVERFLOW_EN
      ovf_acc_reg  <= ovf_acc_next;
      ovf_reg      <= ovf_next;
`endif
    end
  end

  assign result  = result_reg;
  assign ack_tag = ack_reg;
  assign busy    = (state_reg != IDLE);
`ifdef FPGA_COPROC_OVERFLOW_EN
  assign overflow = ovf_reg;
`endif

endmodule

// File: tb/tb_fpga_coproc_poly.sv
// Randomised and directed bench for fpga_coproc_poly against an arithmetic
// reference model; overflow is checked when FPGA_COPROC_OVERFLOW_EN is defined.
module tb_fpga_coproc_poly;

  localparam int DATA_W      = 8;
  localparam int RESULT_W    = 8;
  localparam int ADD_K       = 3;
  localparam int SYNC_STAGES = 2;
  localparam longint M       = longint'(1) << RESULT_W;

  logic                clock   = 1'b0;
  logic                reset_n = 1'b0;
  logic [DATA_W-1:0]   data_in = '0;
  logic [1:0]          mode_in = '0;
  logic                tag_in  = 1'b0;
  logic [RESULT_W-1:0] result;
  logic                ack_tag;
  logic                busy;
`ifdef FPGA_COPROC_OVERFLOW_EN
  logic                overflow;
`endif

  int   vectors    = 0;
  int   miscompares = 0;
  logic exp_ack    = 1'b0;

  fpga_coproc_poly #(
    .DATA_W      (DATA_W),
    .RESULT_W    (RESULT_W),
    .ADD_K       (ADD_K),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .data_in (data_in),
    .mode_in (mode_in),
    .tag_in  (tag_in),
    .result  (result),
    .ack_tag (ack_tag),
    .busy    (busy)
`ifdef FPGA_COPROC_OVERFLOW_EN
    ,
    .overflow(overflow)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Reference: full-precision arithmetic, reduced modulo 2^RESULT_W at each step
  function automatic void model(input int x, input int mode, output longint res,
                                output bit ov, output int lat);
    longint k, p, a, q;
    k  = longint'(ADD_K) % M;
    p  = longint'(x) * longint'(x);
    ov = 1'b0;
    case (mode)
      0: begin res = p % M; ov = (p >= M); lat = 2; end
      1: begin
        a = (p % M) + k;
        res = a % M; ov = (p >= M) || (a >= M); lat = 3;
      end
      2: begin
        a = (p % M) + k;
        q = (a % M) * (a % M);
        res = q % M; ov = (p >= M) || (a >= M) || (q >= M); lat = 4;
      end
      default: begin res = longint'(x); lat = 2; end
    endcase
  endfunction

  task automatic wait_ack(output int cycles, output int busy_cnt);
    logic start;
    start    = ack_tag;
    cycles   = 0;
    busy_cnt = 0;
    while (cycles < 60) begin
      @(negedge clock);
      cycles++;
      if (busy) busy_cnt++;
      if (ack_tag !== start) break;
    end
  endtask

  task automatic check_done(input string tag, input int x, input int mode);
    longint res;
    bit     ov;
    int     lat;
    model(x, mode, res, ov, lat);
    exp_ack = ~exp_ack;
    check({tag, "_ack"}, 32'(ack_tag), 32'(exp_ack));
    check({tag, "_res"}, 32'(result), 32'(res));
`ifdef FPGA_COPROC_OVERFLOW_EN
    check({tag, "_ovf"}, 32'(overflow), 32'(ov));
`endif
  endtask

  task automatic present(input int x, input int mode);
    @(negedge clock);
    data_in = DATA_W'(x);
    mode_in = 2'(mode);
    @(negedge clock);
    tag_in = ~tag_in;
  endtask

  task automatic request(input string tag, input int x, input int mode);
    longint res;
    bit     ov;
    int     lat, cycles, busy_cnt;
    model(x, mode, res, ov, lat);
    present(x, mode);
    wait_ack(cycles, busy_cnt);
    check({tag, "_lat"}, 32'(cycles), 32'(SYNC_STAGES + lat));
    check({tag, "_busy"}, 32'(busy_cnt), 32'(lat - 1));
    check_done(tag, x, mode);
  endtask

  task automatic wait_busy(output int cycles);
    cycles = 0;
    while (cycles < 20 && busy !== 1'b1) begin
      @(negedge clock);
      cycles++;
    end
  endtask

  initial begin
    int cycles, busy_cnt, x, mode;

    repeat (3) @(negedge clock);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ack", 32'(ack_tag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef FPGA_COPROC_OVERFLOW_EN
    check("rst_ovf", 32'(overflow), 32'd0);
`endif
    reset_n = 1'b1;

    // Idle with constant tag: nothing may happen
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (i % 5 == 4) begin
        check("idle_ack", 32'(ack_tag), 32'd0);
        check("idle_result", 32'(result), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
      end
    end

    request("x2_m2", 2, 2);
    request("x5_m2", 5, 2);
    request("x15_m0", 15, 0);
    request("x16_m1", 16, 1);
    request("xA5_m3", 'hA5, 3);
    request("xFF_m2", 'hFF, 2);
    request("x0_m1", 0, 1);

    for (int i = 0; i < 40; i++) begin
      x    = int'($urandom_range(0, (1 << DATA_W) - 1));
      mode = int'($urandom_range(0, 3));
      request($sformatf("rnd%0d_m%0d", i, mode), x, mode);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    // Two toggles while busy cancel: one ack only
    present(7, 2);
    wait_busy(cycles);
    check("dbl_busy_seen", 32'(busy), 32'd1);
    tag_in = ~tag_in;
    @(negedge clock);
    tag_in = ~tag_in;
    wait_ack(cycles, busy_cnt);
    check_done("dbl", 7, 2);
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (busy) busy_cnt++;
    end
    check("dbl_no_second_busy", 32'(busy_cnt), 32'd0);
    check("dbl_no_second_ack", 32'(ack_tag), 32'(exp_ack));

    // One extra toggle while busy queues a second request on the same operand
    present(9, 2);
    wait_busy(cycles);
    tag_in = ~tag_in;
    wait_ack(cycles, busy_cnt);
    check_done("pend_first", 9, 2);
    wait_ack(cycles, busy_cnt);
    check("pend_second_lat", 32'(cycles <= 6), 32'd1);
    check_done("pend_second", 9, 2);
    repeat (3) @(negedge clock);

    // Reset while in ADD aborts the request
    present(6, 2);
    wait_busy(cycles);
    reset_n = 1'b0;
    tag_in  = 1'b0;
    exp_ack = 1'b0;
    #1;
    check("abort_result", 32'(result), 32'd0);
    check("abort_ack", 32'(ack_tag), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
`ifdef FPGA_COPROC_OVERFLOW_EN
    check("abort_ovf", 32'(overflow), 32'd0);
`endif
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check("post_rst_ack", 32'(ack_tag), 32'd0);
    request("post_rst_x3_m2", 3, 2);
    request("post_rst_x200_m1", 200, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpga_coproc_poly.md
Name: fpga_coproc_poly

Overview:
Parametrised successor to the fixed ((x*x)+3)^2 port coprocessor. An MCU writes an operand and a mode over GPIO, then toggles a request tag. The block computes the selected polynomial over a shared adder and multiplier, registers the result and toggles an acknowledge tag back. It sits between the MCU port pins and the display driver in the FPGA top level.

Parameters:
DATA_W, 8, operand width from the MCU port
RESULT_W, 8, result and internal datapath width; all arithmetic is modulo 2^RESULT_W
ADD_K, 3, constant added in modes 1 and 2; truncated to RESULT_W
SYNC_STAGES, 2, input synchroniser depth; legal values are 2 and up

Ports:
clock  in  1  single clock
reset_n  in  1  asynchronous, active-low reset
data_in  in  DATA_W  operand, asynchronous to clock
mode_in  in  2  0: x*x; 1: x*x+K; 2: (x*x+K)^2; 3: pass x through
tag_in  in  1  request tag; each toggle is one request
result  out  RESULT_W  registered result of the last completed request
ack_tag  out  1  toggles once per completed request
busy  out  1  high in every state except IDLE
overflow  out  1  only when FPGA_COPROC_OVERFLOW_EN is defined

Behaviour:
- Reset is asynchronous, active-low. On reset: result=0, ack_tag=0, busy=0, overflow=0, state=IDLE, all synchroniser flops=0, first=1.
- Inputs: data_in, mode_in and tag_in each pass through SYNC_STAGES flops before use.
- Host contract: hold data_in and mode_in stable from before the tag toggle until ack_tag toggles.
- First IDLE cycle after reset (first=1): load prev_tag from the synchronised tag and clear first. No computation and no ack.
- IDLE: a request is detected when synchronised tag != prev_tag. On detection, in the same cycle:
  - prev_tag <= tag; capture the operand x (zero-extended to RESULT_W) and the mode.
  - Drive the multiplier with x*x; r_mul <= product.
  - Next state: DONE for modes 0 and 3, ADD for modes 1 and 2.
- ADD: r_add <= r_mul + ADD_K. Next state is MUL2 for mode 2, DONE for mode 1.
- MUL2: r_mul <= r_add*r_add. Next state is DONE.
- DONE: result <= the selected value, ack_tag <= ~ack_tag, next state is IDLE.
  - Mode 0 and mode 2 select r_mul.
  - Mode 1 selects r_add.
  - Mode 3 selects captured x.
- Adder and multiplier inputs are 0 in every state that does not use them.
- Latency, counted from the IDLE detect edge to the result/ack update edge inclusive: mode 0: 2, mode 1: 3, mode 2: 4, mode 3: 2. busy is high for latency-1 cycles.
- Tag toggles while busy are not lost. They are compared against prev_tag on return to IDLE. Two toggles while busy cancel and produce no request (documented host rule: one outstanding request).
- A mode change mid-operation has no effect; the mode captured in IDLE is used.
- Reset mid-operation aborts immediately: result=0 and no ack. The next request after reset re-arms via first.
- Back-to-back requests: IDLE is occupied for at least one cycle between requests.

Optional Feature:
FPGA_COPROC_OVERFLOW_EN
- Defined: overflow port present.
  - Cleared when a request is accepted in IDLE.
  - Set (sticky within the request) if any full-precision product or sum of that request exceeds 2^RESULT_W-1.
  - Updates on the same edge as result.
  - Requires a 2*RESULT_W-wide product internally.
- Undefined: no overflow port and no extra logic; products are computed at RESULT_W width only.

Decomposition:
- Package fpga_coproc_pkg: state encoding (IDLE, ADD, MUL2, DONE), mode constants (MODE_SQ=0, MODE_SQ_K=1, MODE_POLY=2, MODE_PASS=3), mode width.
- One sub-module: sync_bus (parametrised WIDTH and STAGES, async active-low reset to 0). It is instantiated once for the concatenated {tag, mode, data}.

Test Plan:
- Reset, then hold tag_in constant for 20 cycles -> ack_tag stays 0, result stays 0, busy stays 0.
- x=2, mode 2, tag toggle -> result=49, ack_tag toggles 4 cycles after detect; overflow=0.
- x=5, mode 2 -> 784 mod 256 = 16, result=16, overflow=1. Then x=15, mode 0 -> result=225, 2-cycle latency, overflow=0.
- x=16, mode 1 -> result=3 (256 wraps to 0, then +3), overflow=1. x=0xA5, mode 3 -> result=0xA5.
- Toggle tag twice while busy on a mode 2 request -> exactly one ack and no second computation. A single extra toggle while busy -> second request is served right after IDLE.
- Assert reset_n low during ADD -> result=0, ack_tag=0 immediately; after release, a new request completes normally.
